// File: rtl/apb_mem_param.sv
//==============================================================================
// Module      : apb_mem_param
// Description : APB slave backed by a DEPTH x DATA_W register memory with
//               byte-lane write strobes and per-transfer wait-state insertion
//               driven by PWAIT. Out-of-range word indices never touch the
//               memory and read back as zero.
//               Optional feature macro: APB_MEM_PSLVERR_EN -- when defined,
//               PSLVERR is raised with PREADY on out-of-range transfers; when
//               undefined, PSLVERR is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_mem_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [3:0]            PWAIT,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic                  PREADY,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PSLVERR
);

    localparam int C_STRB_W   = DATA_W / 8;
    localparam int C_ADDR_LSB = $clog2(C_STRB_W);
    localparam int C_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // SETUP is the first access-phase cycle of a transfer that asked for wait
    // states; a zero-wait transfer goes straight from the bus setup phase to
    // ACCESS so that PREADY lands in the first access-phase cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } state_t;

    state_t                r_state_q,   w_state_d;
    logic [3:0]            r_cnt_q,     w_cnt_d;
    logic [ADDR_W-1:0]     r_addr_q,    w_addr_d;
    logic                  r_write_q,   w_write_d;
    logic [DATA_W-1:0]     r_wdata_q,   w_wdata_d;
    logic [C_STRB_W-1:0]   r_strb_q,    w_strb_d;
    logic                  r_pready_q,  w_pready_d;
    logic                  r_pslverr_q, w_pslverr_d;
    logic [DATA_W-1:0]     r_prdata_q,  w_prdata_d;
    logic [DATA_W-1:0]     r_mem_q [DEPTH];

    logic                  w_start;
    logic                  w_active;
    logic [ADDR_W-1:0]     w_acc_addr;
    logic                  w_acc_write;
    logic [ADDR_W-1:0]     w_acc_idx;
    logic                  w_acc_in_range;
    logic [ADDR_W-1:0]     w_wr_idx;
    logic                  w_wr_in_range;
    logic                  w_wr_en;
    logic [DATA_W-1:0]     w_wr_word;

    // Bus phase decode: a new transfer may start from IDLE (or right after an
    // ACCESS cycle); SETUP/WAIT need PSEL and PENABLE held high to continue.
    always_comb begin
        w_start  = PSEL && !PENABLE &&
                   ((r_state_q == ST_IDLE) || (r_state_q == ST_ACCESS));
        w_active = PSEL && PENABLE;
    end

    // Next-state, wait counter and request capture.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_write_d = r_write_q;
        w_wdata_d = r_wdata_q;
        w_strb_d  = r_strb_q;
        case (r_state_q)
            ST_IDLE, ST_ACCESS: begin
                if (w_start) begin
                    w_addr_d  = PADDR;
                    w_write_d = PWRITE;
                    w_wdata_d = PWDATA;
                    w_strb_d  = PSTRB;
                    w_cnt_d   = PWAIT;
                    w_state_d = (PWAIT == 4'd0) ? ST_ACCESS : ST_SETUP;
                end else begin
                    w_cnt_d   = 4'd0;
                    w_state_d = ST_IDLE;
                end
            end
            ST_SETUP, ST_WAIT: begin
                if (!w_active) begin
                    // Master gave up before PREADY: drop the transfer.
                    w_cnt_d   = 4'd0;
                    w_state_d = ST_IDLE;
                end else begin
                    // One wait cycle is consumed per clock; the cycle that
                    // brings the count to zero is the last one with PREADY=0.
                    w_cnt_d   = (r_cnt_q == 4'd0) ? 4'd0 : 4'(r_cnt_q - 4'd1);
                    w_state_d = (r_cnt_q <= 4'd1) ? ST_ACCESS : ST_WAIT;
                end
            end
            default: begin
                w_cnt_d   = 4'd0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Registered response: computed from the transfer about to enter ACCESS.
    // A zero-wait transfer is still being captured, so it uses the bus inputs.
    always_comb begin
        w_acc_addr     = w_start ? PADDR  : r_addr_q;
        w_acc_write    = w_start ? PWRITE : r_write_q;
        w_acc_idx      = w_acc_addr >> C_ADDR_LSB;
        w_acc_in_range = ({1'b0, w_acc_idx} < (ADDR_W + 1)'(DEPTH));
        w_pready_d     = (w_state_d == ST_ACCESS);
        w_prdata_d     = '0;
        if (w_pready_d && !w_acc_write && w_acc_in_range) begin
            w_prdata_d = r_mem_q[w_acc_idx[C_IDX_W-1:0]];
        end
`ifdef APB_MEM_PSLVERR_EN
        w_pslverr_d    = w_pready_d && !w_acc_in_range;
`else
        w_pslverr_d    = 1'b0;
`endif
    end

    // Write commit at the edge closing ACCESS, merging only strobed lanes.
    always_comb begin
        w_wr_idx      = r_addr_q >> C_ADDR_LSB;
        w_wr_in_range = ({1'b0, w_wr_idx} < (ADDR_W + 1)'(DEPTH));
        w_wr_en       = (r_state_q == ST_ACCESS) && w_active &&
                        r_write_q && w_wr_in_range;
        w_wr_word     = r_mem_q[w_wr_idx[C_IDX_W-1:0]];
        for (int i = 0; i < C_STRB_W; i++) begin
            if (r_strb_q[i]) begin
                w_wr_word[i*8 +: 8] = r_wdata_q[i*8 +: 8];
            end
        end
    end

    // Control and response flops.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= 4'd0;
            r_addr_q    <= '0;
            r_write_q   <= 1'b0;
            r_wdata_q   <= '0;
            r_strb_q    <= '0;
            r_pready_q  <= 1'b0;
            r_pslverr_q <= 1'b0;
            r_prdata_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_addr_q    <= w_addr_d;
            r_write_q   <= w_write_d;
            r_wdata_q   <= w_wdata_d;
            r_strb_q    <= w_strb_d;
            r_pready_q  <= w_pready_d;
            r_pslverr_q <= w_pslverr_d;
            r_prdata_q  <= w_prdata_d;
        end
    end

    // Memory array; reset clears every word.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem_q[w_wr_idx[C_IDX_W-1:0]] <= w_wr_word;
        end
    end

    assign PREADY  = r_pready_q;
    assign PRDATA  = r_prdata_q;
    assign PSLVERR = r_pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_param.sv
//==============================================================================
// Module      : tb_apb_mem_param
// Description : Scoreboard bench for apb_mem_param (DEPTH=32, DATA_W=32).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_mem_param;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
`ifdef APB_MEM_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              pclk = 1'b0;
    logic              preset;
    logic [3:0]        pwait;
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    apb_mem_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PWAIT   (pwait),
        .PSEL    (psel),
        .PENABLE (penable),
        .PADDR   (paddr),
        .PWRITE  (pwrite),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PREADY  (pready),
        .PRDATA  (prdata),
        .PSLVERR (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wait_cnt = 0;

    // Monitor: pops one expectation per PREADY and checks idle-cycle outputs.
    always @(negedge pclk) begin
        if (!preset) begin
            if (psel && !penable) wait_cnt = 0;
            if (pready) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pready: got PREADY=1, expected no transfer completing");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checks++;
                    if (prdata !== e.rdata) begin
                        failures++;
                        $display("FAIL xfer%0d_prdata: got %h, expected %h", e.id, prdata, e.rdata);
                    end
                    checks++;
                    if (pslverr !== e.err) begin
                        failures++;
                        $display("FAIL xfer%0d_pslverr: got %b, expected %b", e.id, pslverr, e.err);
                    end
                    checks++;
                    if (wait_cnt != e.waits) begin
                        failures++;
                        $display("FAIL xfer%0d_waits: got %0d, expected %0d", e.id, wait_cnt, e.waits);
                    end
                end
                wait_cnt = 0;
            end else begin
                if (psel && penable) wait_cnt++;
                checks++;
                if (prdata !== '0 || pslverr !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_outputs: got PRDATA=%h PSLVERR=%b, expected 0/0", prdata, pslverr);
                end
            end
        end
    end

    // Full APB transfer; caller is at posedge+1. Expectation queued at issue.
    task automatic xfer(input int id, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input logic [3:0] w, input logic [31:0] exp_rd,
                        input logic exp_err);
        exp_t e;
        int   n;
        e.id    = id;
        e.rdata = wr ? 32'h0 : exp_rd;
        e.err   = exp_err;
        e.waits = int'(w);
        sb_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wd; pstrb = strb; pwait = w;
        @(posedge pclk); #1 penable = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge pclk);
            if (pready) break;
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL xfer%0d_timeout: got no PREADY in 40 cycles, expected PREADY", id);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwait = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) begin
            failures++;
            $display("FAIL %s: got PREADY=%b PRDATA=%h PSLVERR=%b, expected 0/0/0",
                     name, pready, prdata, pslverr);
        end
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pwait = '0;
        repeat (3) @(posedge pclk);
        #1 check_zero_outputs("reset_state");
        preset = 1'b0;

        // Basic write/read, zero waits
        xfer(1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0, 1'b0);
        xfer(2, 1'b0, 8'h10, 32'h0, 4'h0, 4'd0, 32'hDEADBEEF, 1'b0);
        idle(1);
        // Partial strobes and wait states
        xfer(3, 1'b1, 8'h10, 32'h11223344, 4'h5, 4'd1, 32'h0, 1'b0);
        xfer(4, 1'b0, 8'h10, 32'h0, 4'hF, 4'd3, 32'hDE22BE44, 1'b0);
        // Unaligned address, PSTRB=0 leaves the word unchanged
        xfer(5, 1'b1, 8'h13, 32'hAABBCCDD, 4'h0, 4'd0, 32'h0, 1'b0);
        xfer(6, 1'b0, 8'h12, 32'h0, 4'h0, 4'd2, 32'hDE22BE44, 1'b0);
        idle(2);
        // Back-to-back write then read of the same word
        xfer(7, 1'b1, 8'h04, 32'hCAFEF00D, 4'hF, 4'd0, 32'h0, 1'b0);
        xfer(8, 1'b0, 8'h04, 32'h0, 4'h0, 4'd0, 32'hCAFEF00D, 1'b0);
        // Last valid word (index 31)
        xfer(9,  1'b0, 8'h7C, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
        xfer(10, 1'b1, 8'h7C, 32'h01020304, 4'hF, 4'd1, 32'h0, 1'b0);
        xfer(11, 1'b0, 8'h7C, 32'h0, 4'h0, 4'd0, 32'h01020304, 1'b0);
        // First out-of-range word (index 32): write dropped, must not alias word 0
        xfer(12, 1'b1, 8'h80, 32'h55555555, 4'hF, 4'd0, 32'h0, ERR_EN);
        xfer(13, 1'b0, 8'h80, 32'h0, 4'h0, 4'd1, 32'h0, ERR_EN);
        xfer(14, 1'b0, 8'h00, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
        idle(1);

        // Aborted write: PENABLE dropped mid-WAIT, no PREADY and no write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
        pwdata = 32'h12345678; pstrb = 4'hF; pwait = 4'd6;
        @(posedge pclk); #1 penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwait = 4'd0;
        idle(8);
        xfer(15, 1'b0, 8'h04, 32'h0, 4'h0, 4'd0, 32'hCAFEF00D, 1'b0);

        // Reset asserted during WAIT of a write to 0x20
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pwait = 4'd5;
        @(posedge pclk); #1 penable = 1'b1;
        repeat (2) @(posedge pclk);
        #3 preset = 1'b1;
        #1 check_zero_outputs("reset_async");
        psel = 1'b0; penable = 1'b0; pwait = 4'd0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        xfer(16, 1'b0, 8'h20, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
        xfer(17, 1'b0, 8'h10, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
        xfer(18, 1'b0, 8'h04, 32'h0, 4'h0, 4'd2, 32'h0, 1'b0);

        idle(3);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/apb_mem_param.md
APB_MEM_PARAM -- requirements
Module: apb_mem_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PADDR width in bits (byte address).
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; legal values 8, 16, 32, 64.
REQ-003 SHALL have parameter DEPTH, default 64, number of DATA_W-bit words; DEPTH*(DATA_W/8) <= 2**ADDR_W.
REQ-004 SHALL have port PCLK  input  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PWAIT  input  4  wait states to insert for the current transfer, sampled in setup.
REQ-007 SHALL have port PSEL  input  1  APB select.
REQ-008 SHALL have port PENABLE  input  1  APB enable (access phase).
REQ-009 SHALL have port PADDR  input  ADDR_W  byte address.
REQ-010 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-011 SHALL have port PWDATA  input  DATA_W  write data.
REQ-012 SHALL have port PSTRB  input  DATA_W/8  write byte-lane enables.
REQ-013 SHALL have port PREADY  output  1  transfer completes this cycle.
REQ-014 SHALL have port PRDATA  output  DATA_W  read data, valid only while PREADY=1 on a read.
REQ-015 SHALL have port PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP, WAIT, ACCESS.
REQ-017 IDLE -> SETUP when PSEL=1 and PENABLE=0; in that cycle latch PADDR, PWRITE, PWDATA, PSTRB, and load wait counter with PWAIT.
REQ-018 SETUP -> ACCESS when the latched count is 0, else SETUP -> WAIT; WAIT decrements once per cycle and moves to ACCESS after the cycle in which the count reaches 0.
REQ-019 PREADY and PSLVERR SHALL be registered, asserted only in ACCESS and for exactly one cycle per transfer; PWAIT=N gives N cycles of PENABLE=1, PREADY=0 before the PREADY=1 cycle.
REQ-020 Word index SHALL be PADDR >> log2(DATA_W/8); lower address bits are ignored (no misalignment error).
REQ-021 Write SHALL update only the byte lanes with PSTRB[i]=1, at the rising edge that ends the ACCESS cycle; PSTRB=0 completes normally with no memory change.
REQ-022 Read SHALL drive PRDATA = mem[index] in the ACCESS cycle; PRDATA SHALL be 0 in all other cycles; PSTRB ignored on reads.
REQ-023 Index >= DEPTH SHALL be out of range: write suppressed, PRDATA=0.
REQ-024 ACCESS -> SETUP if the following cycle has PSEL=1, PENABLE=0 (back-to-back); otherwise ACCESS -> IDLE.
REQ-025 If PSEL or PENABLE drops in SETUP+1, WAIT, or ACCESS before PREADY=1, the transfer SHALL abort: FSM -> IDLE, no write, no PREADY.
REQ-026 A write followed immediately by a read of the same word SHALL return the newly written data.

Reset
REQ-027 PRESET=1 SHALL asynchronously force FSM to IDLE and PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, and all memory words to 0.
REQ-028 Reset asserted mid-transfer SHALL discard the transfer with no memory write; first transfer is accepted on the first PCLK edge after PRESET deasserts.

Configuration
REQ-029 Macro APB_MEM_PSLVERR_EN defined: PSLVERR=1 with PREADY on out-of-range transfers, 0 otherwise.
REQ-030 Macro APB_MEM_PSLVERR_EN undefined: PSLVERR tied 0; out-of-range reads return 0 and writes are silently dropped.

Verification
REQ-031 Write PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=0xF, PWAIT=0 -> PREADY in the first access cycle; a read of 0x10 returns 0xDEADBEEF.
REQ-032 Write PWDATA=0x11223344 with PSTRB=0x5 over existing word 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-033 Read with PWAIT=3 -> exactly 3 access cycles with PREADY=0, then one cycle with PREADY=1 and correct data.
REQ-034 With macro defined, read PADDR=0xFC (index 63 valid) -> PSLVERR=0; with DEPTH=32, PADDR=0x80 -> PSLVERR=1, PRDATA=0, write dropped.
REQ-035 Assert PRESET during WAIT of a write to 0x20 -> outputs 0 immediately; later read of 0x20 returns 0x00000000.
REQ-036 Back-to-back write 0x04 then read 0x04 with no idle cycle -> read returns the written value; deassert PENABLE mid-WAIT -> no PREADY, no write.
